hs_npu_output_deskew: RTL
=========================

Name: hs_npu_output_deskew

Overview:
- Sits directly downstream of the NPU matrix-multiply unit and consumes its per-column output results.
- Upstream, each column delivers one element per valid pulse. Rows arrive skewed: column j lags column j-1 by a cycle.
- The block buffers each column, realigns the elements into complete rows, and applies optional ReLU plus a rounding right-shift with saturation to the narrow activation width.
- Rows leave on a single ready/valid interface toward the output memory writer or the next layer's input loader.

Parameters:
- SIZE, 8, number of columns (systolic array width).
- IN_WIDTH, 32, signed accumulator width per column.
- OUT_WIDTH, 16, signed requantized output width per column.
- DEPTH, 4, per-column row buffer depth (power of two, ≥2).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- flush  in  1  synchronous clear of all buffered data and the output register.
- in_data[SIZE]  in  IN_WIDTH  per-column result from the matrix-multiply unit.
- in_valid[SIZE]  in  1  per-column element strobe. No backpressure is possible upstream.
- relu_en  in  1  clamp negative values to 0 before shifting.
- shift  in  5  arithmetic right-shift amount, 0..31. Static while rows are in flight.
- out_data[SIZE]  out  OUT_WIDTH  requantized row.
- out_valid  out  1  out_data holds a row.
- out_ready  in  1  downstream accepts the row.
- overflow  out  1  sticky: an element was dropped because its column buffer was full.
- rows_out  out  16  count of rows accepted downstream, wraps modulo 2^16.

Behaviour:
- Reset (rst=1 at an edge):
  - All column buffers are emptied.
  - out_valid=0, out_data=0, overflow=0, rows_out=0.
  - Reset mid-row discards partial rows.
- Flush:
  - Same clearing as reset, except rows_out is kept.
  - Flush has priority over a same-cycle push, pop or handshake. Those events are ignored, and rows_out does not increment even if out_valid&out_ready.
- Column buffer j is a circular buffer with write pointer, read pointer and count (0..DEPTH):
  - in_valid[j]=1 pushes in_data[j] at the edge, provided count_after_pop < DEPTH.
  - Otherwise the element is dropped and overflow is set to 1, staying set until rst or flush.
  - Pointers wrap modulo DEPTH.
- Row complete: all SIZE column counts ≥1 (combinational).
- Pop/load:
  - Condition: row complete AND (out_valid=0 OR out_ready=1).
  - Action: all columns pop one entry simultaneously, the processed row is loaded into the out_data register, and out_valid=1.
  - A push to a full column in the same cycle as a pop is accepted.
- Output hold:
  - When out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - On out_valid&out_ready with no new load, out_valid falls to 0.
  - On each out_valid&out_ready, rows_out increments by 1.
- Latency:
  - Empty block, last column element pushed at edge E: out_valid=1 after edge E+1 (2 cycles from in_valid[SIZE-1] high to out_valid high).
  - Steady state with out_ready=1: one row per cycle.
- Per-element arithmetic, computed on the popped value x (signed IN_WIDTH):
  - ReLU: v = (relu_en && x<0) ? 0 : x.
  - Rounding: if shift>0, v = v + 2^(shift-1), in IN_WIDTH+1 bits. Round half up.
  - Shift: v = v >>> shift (arithmetic).
  - Saturation: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Columns never reorder. Row n is formed from the n-th element received on every column, independent of skew magnitude, provided no drops occur.

Test Plan:
- Reset then idle: rst for 2 cycles, no in_valid → out_valid=0, overflow=0, rows_out=0 for 10 cycles.
- Skewed single row: column j gets value 100*(j+1) with in_valid[j] in cycle j; shift=0, relu_en=0 → one row 100,200,…,800. out_valid rises in cycle SIZE+1 (2 cycles after column 7's strobe). rows_out=1 after the handshake.
- Requantize/saturate: inputs -300, 300, 70000, -70000, 5, -5, 0, 2^31-1; shift=1; relu_en=1 → outputs 0, 150, 32767, 0, 3, 0, 0, 32767. Repeat with relu_en=0 → -300 gives -150, -70000 gives -32768, -5 gives -2.
- Backpressure: stream 6 skewed rows with out_ready=0 → first row held stable, no drops through row DEPTH+1 (4 buffered + 1 in output register). Row 6 sets overflow=1. Releasing out_ready yields rows 1..5 in order on consecutive cycles.
- Full-buffer simultaneous push/pop: column 0 full, out_ready=1 and a row completing in the same cycle as in_valid[0] → element accepted, overflow stays 0.
- Flush mid-operation: 3 of 8 columns pushed, then flush while out_valid=1 and out_ready=1 → out_valid=0 next cycle, rows_out unchanged, overflow cleared. A following complete row emerges correctly with no stale data.

Source files
------------

// File: rtl/hs_npu_output_deskew.sv
// Output deskew and requantize stage for the NPU matrix-multiply unit.
// Each column result is queued in its own small circular buffer. A row is
// released when every column holds at least one element, so the diagonal
// skew of the systolic array is absorbed here. Released elements pass
// through optional ReLU, a round-half-up arithmetic right shift and
// saturation to OUT_WIDTH before being registered on a ready/valid output.
module hs_npu_output_deskew #(
  parameter int SIZE      = 8,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [SIZE-1:0][IN_WIDTH-1:0]    in_data,
  input  logic [SIZE-1:0]                  in_valid,
  input  logic                             relu_en,
  input  logic [4:0]                       shift,
  output logic [SIZE-1:0][OUT_WIDTH-1:0]   out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             overflow,
  output logic [15:0]                      rows_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] SAT_MIN =
    {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic [IN_WIDTH-1:0] mem [SIZE][DEPTH];
  logic [PTR_W-1:0]    wr_ptr [SIZE];
  logic [PTR_W-1:0]    rd_ptr [SIZE];
  logic [CNT_W-1:0]    cnt    [SIZE];

  logic                            row_complete;
  logic                            pop;
  logic                            handshake;
  logic [SIZE-1:0]                 push;
  logic [SIZE-1:0]                 drop;
  logic [SIZE-1:0][OUT_WIDTH-1:0]  row_q;

  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic [OUT_WIDTH-1:0] requant(
    input logic [IN_WIDTH-1:0] x,
    input logic                relu,
    input logic [4:0]          sh
  );
    logic signed [IN_WIDTH:0] v;
    logic signed [IN_WIDTH:0] rnd;
    logic signed [IN_WIDTH:0] s;
    logic [OUT_WIDTH-1:0]     res;
    v = {x[IN_WIDTH-1], x};
    if (relu && x[IN_WIDTH-1]) v = '0;
    rnd = '0;
    if (sh != 5'd0) rnd = $signed({{IN_WIDTH{1'b0}}, 1'b1} << (sh - 5'd1));
    s = (v + rnd) >>> sh;
    if (s > SAT_MAX)      res = SAT_MAX[OUT_WIDTH-1:0];
    else if (s < SAT_MIN) res = SAT_MIN[OUT_WIDTH-1:0];
    else                  res = s[OUT_WIDTH-1:0];
    return res;
  endfunction

  // Row-ready detection, pop/push arbitration and the requantized head row.
  always_comb begin
    row_complete = 1'b1;
    push         = '0;
    drop         = '0;
    row_q        = '0;
    for (int j = 0; j < SIZE; j++) begin
      if (cnt[j] == '0) row_complete = 1'b0;
    end
    pop       = row_complete && (!out_valid || out_ready);
    handshake = out_valid && out_ready;
    for (int j = 0; j < SIZE; j++) begin
      // A full column still accepts a push when the same edge pops it.
      push[j]  = in_valid[j] && ((cnt[j] != CNT_FULL) || pop);
      drop[j]  = in_valid[j] && !push[j];
      row_q[j] = requant(mem[j][rd_ptr[j]], relu_en, shift);
    end
  end

  // Per-column pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int j = 0; j < SIZE; j++) begin
        wr_ptr[j] <= '0;
        rd_ptr[j] <= '0;
        cnt[j]    <= '0;
      end
    end else begin
      for (int j = 0; j < SIZE; j++) begin
        if (push[j]) wr_ptr[j] <= wr_ptr[j] + PTR_W'(1);
        if (pop)     rd_ptr[j] <= rd_ptr[j] + PTR_W'(1);
        case ({push[j], pop})
          2'b10:   cnt[j] <= cnt[j] + CNT_W'(1);
          2'b01:   cnt[j] <= cnt[j] - CNT_W'(1);
          default: cnt[j] <= cnt[j];
        endcase
      end
    end
  end

  // Column storage; contents are don't-care once the counts are cleared.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int j = 0; j < SIZE; j++) begin
        if (push[j]) mem[j][wr_ptr[j]] <= in_data[j];
      end
    end
  end

  // Output register, sticky overflow flag and accepted-row counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      rows_out  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (handshake) rows_out <= rows_out + 16'd1;
      if (pop) begin
        out_data  <= row_q;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
      if (|drop) overflow <= 1'b1;
    end
  end

endmodule
